// File: rtl/mb_pkg.sv
// Shared types and helpers for the modified-Booth codec/accumulator family.
// Holds the Booth digit encoding, the row-count formula and the FSM states.
package mb_pkg;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } mbe_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } mbpp_state_e;

  function automatic int pp_num(input int n_dw);
    return (n_dw % 2 != 0) ? n_dw / 2 + 2
                           : n_dw / 2 + 1;
  endfunction

endpackage

// File: rtl/mbpp_csa32.sv
// 3:2 carry-save compressor followed by a carry-propagate adder.
// Ports: a, b, c (W-bit addends), sum (W-bit, carry-out dropped).
module mbpp_csa32 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum
);

  logic [W-1:0] s;
  logic [W-1:0] maj;

  assign s   = a ^ b ^ c;
  assign maj = (a & b) | (a & c) | (b & c);
  assign sum = s + (maj << 1);

endmodule

// File: rtl/mbpp_accum.sv
// Sequential partial-product accumulator: sums a Booth PP-row array into a product.
// Ports: clk_i, rst_i, pp_valid_i/pp_ready_o/pp_i in, prod_valid_o/prod_ready_i/prod_o out, busy_o.
module mbpp_accum
  import mb_pkg::*;
#(
  parameter  int M_DW         = 8,
  parameter  int N_DW         = 8,
  parameter  int ROWS_PER_CYC = 1,
  localparam int C_DW         = M_DW + N_DW,
  localparam int PP           = pp_num(N_DW)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pp_valid_i,
  output logic                 pp_ready_o,
  input  logic [PP*C_DW-1:0]   pp_i,
  output logic                 prod_valid_o,
  input  logic                 prod_ready_i,
  output logic [C_DW-1:0]      prod_o,
  output logic                 busy_o
);

  localparam int ITER     = (PP + ROWS_PER_CYC - 1) / ROWS_PER_CYC;
  localparam int CW       = $clog2(ITER + 1);
  localparam int ROWS_PAD = ITER * ROWS_PER_CYC;
  localparam int RW       = ROWS_PAD * C_DW;
  localparam int SH       = ROWS_PER_CYC * C_DW;

  if (ROWS_PER_CYC != 1 && ROWS_PER_CYC != 2) begin : g_bad_rpc
    $error("mbpp_accum: ROWS_PER_CYC must be 1 or 2");
  end

  mbpp_state_e state_q;
  mbpp_state_e state_d;

  logic [CW-1:0]                  cnt_q;
  logic [C_DW-1:0]                acc_q;
  logic [C_DW-1:0]                acc_sum;
  // Rows shift down as they are consumed, so the adder always reads
  // slot 0 (and 1); zero padding covers the missing row of an odd PP.
  logic [ROWS_PAD-1:0][C_DW-1:0]  row_q;
  logic                           accept;

  if (ROWS_PER_CYC == 2) begin : g_rpc2
    mbpp_csa32 #(
      .W(C_DW)
    ) u_csa (
      .a  (acc_q),
      .b  (row_q[0]),
      .c  (row_q[1]),
      .sum(acc_sum)
    );
  end else begin : g_rpc1
    assign acc_sum = acc_q + row_q[0];
  end

  always_comb begin
    state_d      = state_q;
    pp_ready_o   = 1'b0;
    prod_valid_o = 1'b0;
    busy_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        pp_ready_o = 1'b1;
        if (pp_valid_i) state_d = ACC;
      end
      ACC: begin
        busy_o = 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = DONE;
      end
      DONE: begin
        prod_valid_o = 1'b1;
        pp_ready_o   = prod_ready_i;
        if (prod_ready_i) state_d = pp_valid_i ? ACC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = pp_valid_i & pp_ready_o;
  assign prod_o = acc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      row_q <= RW'(pp_i);
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == ACC) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + CW'(1);
      row_q <= row_q >> SH;
    end
  end

endmodule
